// File: rtl/gppcu_seq_pkg.sv
// Shared definitions for the GPPCU instruction sequencer: sequencer states
// and the default geometry of the instruction path.
package gppcu_seq_pkg;

   localparam int DEFAULT_DBW        = 32;
   localparam int DEFAULT_IABW       = 10;
   localparam int DEFAULT_FIFO_DEPTH = 4;
   // Counters must hold a full program length, hence one bit wider than an address.
   localparam int DEFAULT_CW         = DEFAULT_IABW + 1;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_RUN   = 2'd1,
      ST_DRAIN = 2'd2
   } seq_state_e;

endpackage

// File: rtl/gppcu_seq_fifo.sv
// Small synchronous prefetch FIFO. The head entry is visible combinationally
// so the sequencer can present it to the core without an extra cycle.
module gppcu_seq_fifo #(
   parameter int DW     = 32,
   parameter int DEPTH  = 4,
   localparam int AW    = $clog2(DEPTH),
   localparam int OW    = AW + 1
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          flush,
   input  logic          push,
   input  logic [DW-1:0] push_data,
   input  logic          pop,
   output logic [DW-1:0] head_data,
   output logic          full,
   output logic          empty,
   output logic [OW-1:0] occupancy
);

   logic [DW-1:0] mem_r [DEPTH];
   logic [AW-1:0] wr_ptr_r;
   logic [AW-1:0] rd_ptr_r;
   logic [OW-1:0] count_r;
   logic          pop_eff_s;
   logic          push_eff_s;

   // Qualify requests: a pop needs data, a push needs room (a same-cycle pop frees one slot).
   always_comb begin
      pop_eff_s  = pop && (count_r != '0);
      push_eff_s = push && ((count_r != OW'(DEPTH)) || pop_eff_s);
   end

   // Pointer and occupancy bookkeeping; flush empties the buffer in one cycle.
   always_ff @(posedge clk) begin
      if (rst || flush) begin
         wr_ptr_r <= '0;
         rd_ptr_r <= '0;
         count_r  <= '0;
      end else begin
         if (push_eff_s) begin
            wr_ptr_r <= wr_ptr_r + AW'(1);
         end
         if (pop_eff_s) begin
            rd_ptr_r <= rd_ptr_r + AW'(1);
         end
         case ({push_eff_s, pop_eff_s})
            2'b10:   count_r <= count_r + OW'(1);
            2'b01:   count_r <= count_r - OW'(1);
            default: count_r <= count_r;
         endcase
      end
   end

   // Entry storage; cleared on reset so the head never shows stale data after reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem_r[i] <= '0;
         end
      end else if (push_eff_s && !flush) begin
         mem_r[wr_ptr_r] <= push_data;
      end
   end

   assign head_data = mem_r[rd_ptr_r];
   assign full      = (count_r == OW'(DEPTH));
   assign empty     = (count_r == '0);
   assign occupancy = count_r;

endmodule

// File: rtl/gppcu_instr_sequencer.sv
// Instruction sequencer: fetches a contiguous program from instruction memory
// into a small prefetch FIFO and hands instructions to the core over a
// valid/ready handshake. Control outputs are registered; oINSTR/oINSTR_VALID
// come straight from the FIFO head.
module gppcu_instr_sequencer
   import gppcu_seq_pkg::*;
#(
   parameter int DBW        = DEFAULT_DBW,
   parameter int IABW       = DEFAULT_IABW,
   parameter int FIFO_DEPTH = DEFAULT_FIFO_DEPTH
) (
   input  logic            iACLK,
   input  logic            iRST,
   input  logic            iSTART,
   input  logic [IABW-1:0] iSTART_ADDR,
   input  logic [IABW:0]   iINSTR_COUNT,
   input  logic            iABORT,
   output logic            oBUSY,
   output logic            oDONE,
   output logic            oIMEM_RD,
   output logic [IABW-1:0] oIMEM_ADDR,
   input  logic [DBW-1:0]  iIMEM_RDATA,
   output logic [DBW-1:0]  oINSTR,
   output logic            oINSTR_VALID,
   input  logic            iINSTR_READY,
   output logic [IABW:0]   oISSUED
);

   localparam int CW = IABW + 1;
   localparam int OW = $clog2(FIFO_DEPTH) + 1;
   localparam int BW = OW + 1;

   seq_state_e      state_r, state_s;
   logic [IABW-1:0] fetch_addr_r, fetch_addr_s;
   logic [IABW-1:0] imem_addr_r, imem_addr_s;
   logic [CW-1:0]   fetch_cnt_r, fetch_cnt_s;
   logic [CW-1:0]   issue_cnt_r, issue_cnt_s;
   logic [CW-1:0]   issued_r, issued_s;
   logic            rd_r, rd_s;
   logic            inflight_r, inflight_s;
   logic            busy_r, busy_s;
   logic            done_r, done_s;

   logic [DBW-1:0]  fifo_head_s;
   logic            fifo_full_s;
   logic            fifo_empty_s;
   logic [OW-1:0]   fifo_occ_s;
   logic            fifo_push_s;
   logic            fifo_flush_s;
   logic            xfer_s;
   logic [BW-1:0]   budget_s;
   logic            can_read_s;
   logic            last_s;
   logic            fifo_clear_s;
   logic            drain_done_s;

   // Read data lands one cycle after its strobe; an abort discards it via flush priority.
   assign fifo_push_s  = inflight_r;
   assign fifo_flush_s = iABORT;
   assign xfer_s       = !fifo_empty_s && iINSTR_READY;

   // Slots already claimed: stored entries, data arriving now, and the read on the bus now.
   assign budget_s   = BW'(fifo_occ_s) + BW'(rd_r) + BW'(inflight_r);
   assign can_read_s = (fetch_cnt_r != '0) && !fifo_full_s &&
                       (budget_s <= BW'(FIFO_DEPTH - 1));

   // Program finishes when the final instruction is accepted with nothing left behind it.
   assign last_s       = (issue_cnt_r == '0) || (xfer_s && (issue_cnt_r == CW'(1)));
   assign fifo_clear_s = fifo_empty_s || (xfer_s && (fifo_occ_s == OW'(1)));
   assign drain_done_s = last_s && fifo_clear_s && !inflight_r;

   gppcu_seq_fifo #(
      .DW    (DBW),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk       (iACLK),
      .rst       (iRST),
      .flush     (fifo_flush_s),
      .push      (fifo_push_s),
      .push_data (iIMEM_RDATA),
      .pop       (xfer_s),
      .head_data (fifo_head_s),
      .full      (fifo_full_s),
      .empty     (fifo_empty_s),
      .occupancy (fifo_occ_s)
   );

   // Next-state, fetch and issue bookkeeping for the sequencer FSM.
   always_comb begin
      state_s      = state_r;
      fetch_addr_s = fetch_addr_r;
      imem_addr_s  = imem_addr_r;
      fetch_cnt_s  = fetch_cnt_r;
      issue_cnt_s  = issue_cnt_r;
      issued_s     = issued_r;
      rd_s         = 1'b0;
      inflight_s   = rd_r;
      busy_s       = busy_r;
      done_s       = 1'b0;

      // A handshake the core completed always counts, even alongside an abort.
      if (xfer_s) begin
         issued_s    = issued_r + CW'(1);
         issue_cnt_s = issue_cnt_r - CW'(1);
      end else begin
         issued_s    = issued_r;
         issue_cnt_s = issue_cnt_r;
      end

      if (iABORT && (state_r != ST_IDLE)) begin
         state_s     = ST_IDLE;
         busy_s      = 1'b0;
         inflight_s  = 1'b0;
         fetch_cnt_s = '0;
         issue_cnt_s = '0;
      end else begin
         case (state_r)
            ST_IDLE: begin
               if (iSTART && !iABORT) begin
                  if (iINSTR_COUNT != '0) begin
                     // The first read goes out in the cycle right after launch.
                     state_s      = ST_RUN;
                     busy_s       = 1'b1;
                     rd_s         = 1'b1;
                     imem_addr_s  = iSTART_ADDR;
                     fetch_addr_s = iSTART_ADDR + IABW'(1);
                     fetch_cnt_s  = iINSTR_COUNT - CW'(1);
                     issue_cnt_s  = iINSTR_COUNT;
                     issued_s     = '0;
                  end else begin
                     done_s = 1'b1;
                  end
               end else begin
                  state_s = ST_IDLE;
               end
            end
            ST_RUN: begin
               if (can_read_s) begin
                  rd_s         = 1'b1;
                  imem_addr_s  = fetch_addr_r;
                  fetch_addr_s = fetch_addr_r + IABW'(1);
                  fetch_cnt_s  = fetch_cnt_r - CW'(1);
               end else begin
                  rd_s = 1'b0;
               end
               if (fetch_cnt_r == '0) begin
                  state_s = ST_DRAIN;
               end else begin
                  state_s = ST_RUN;
               end
            end
            ST_DRAIN: begin
               if (drain_done_s) begin
                  state_s = ST_IDLE;
                  busy_s  = 1'b0;
                  done_s  = 1'b1;
               end else begin
                  state_s = ST_DRAIN;
               end
            end
            default: begin
               state_s = ST_IDLE;
               busy_s  = 1'b0;
            end
         endcase
      end
   end

   // State and output registers with synchronous reset.
   always_ff @(posedge iACLK) begin
      if (iRST) begin
         state_r      <= ST_IDLE;
         fetch_addr_r <= '0;
         imem_addr_r  <= '0;
         fetch_cnt_r  <= '0;
         issue_cnt_r  <= '0;
         issued_r     <= '0;
         rd_r         <= 1'b0;
         inflight_r   <= 1'b0;
         busy_r       <= 1'b0;
         done_r       <= 1'b0;
      end else begin
         state_r      <= state_s;
         fetch_addr_r <= fetch_addr_s;
         imem_addr_r  <= imem_addr_s;
         fetch_cnt_r  <= fetch_cnt_s;
         issue_cnt_r  <= issue_cnt_s;
         issued_r     <= issued_s;
         rd_r         <= rd_s;
         inflight_r   <= inflight_s;
         busy_r       <= busy_s;
         done_r       <= done_s;
      end
   end

   assign oBUSY        = busy_r;
   assign oDONE        = done_r;
   assign oIMEM_RD     = rd_r;
   assign oIMEM_ADDR   = imem_addr_r;
   assign oISSUED      = issued_r;
   assign oINSTR       = fifo_head_s;
   assign oINSTR_VALID = !fifo_empty_s;

endmodule

// File: tb/tb_gppcu_instr_sequencer.sv
// Directed self-checking bench for gppcu_instr_sequencer.
module tb_gppcu_instr_sequencer;

   localparam int DBW  = 32;
   localparam int IABW = 10;

   logic            iACLK = 1'b0;
   logic            iRST;
   logic            iSTART;
   logic [IABW-1:0] iSTART_ADDR;
   logic [IABW:0]   iINSTR_COUNT;
   logic            iABORT;
   logic            oBUSY;
   logic            oDONE;
   logic            oIMEM_RD;
   logic [IABW-1:0] oIMEM_ADDR;
   logic [DBW-1:0]  iIMEM_RDATA;
   logic [DBW-1:0]  oINSTR;
   logic            oINSTR_VALID;
   logic            iINSTR_READY;
   logic [IABW:0]   oISSUED;

   int checks = 0;
   int errors = 0;

   gppcu_instr_sequencer #(
      .DBW        (DBW),
      .IABW       (IABW),
      .FIFO_DEPTH (4)
   ) dut (
      .iACLK        (iACLK),
      .iRST         (iRST),
      .iSTART       (iSTART),
      .iSTART_ADDR  (iSTART_ADDR),
      .iINSTR_COUNT (iINSTR_COUNT),
      .iABORT       (iABORT),
      .oBUSY        (oBUSY),
      .oDONE        (oDONE),
      .oIMEM_RD     (oIMEM_RD),
      .oIMEM_ADDR   (oIMEM_ADDR),
      .iIMEM_RDATA  (iIMEM_RDATA),
      .oINSTR       (oINSTR),
      .oINSTR_VALID (oINSTR_VALID),
      .iINSTR_READY (iINSTR_READY),
      .oISSUED      (oISSUED)
   );

   always #5 iACLK = ~iACLK;

   // Memory image: each word carries its own address in the low bits.
   function automatic logic [31:0] mdata(input logic [IABW-1:0] a);
      return 32'hC0DE_0000 | {22'd0, a};
   endfunction

   // Instruction memory model: data valid the cycle after the read strobe.
   always @(posedge iACLK) begin
      iIMEM_RDATA <= oIMEM_RD ? mdata(oIMEM_ADDR) : 32'hDEAD_BEEF;
   end

   // Monitor: records reads, transfers, done pulses and stall stability.
   int              cyc = 0;
   logic [IABW-1:0] rd_addr_q [$];
   int              rd_cyc_q  [$];
   logic [DBW-1:0]  xfer_q    [$];
   int              xfer_cyc_q[$];
   int              done_cnt   = 0;
   int              stall_cnt  = 0;
   int              stall_viol = 0;
   logic            prev_stall = 1'b0;
   logic [DBW-1:0]  prev_instr = '0;

   always @(negedge iACLK) begin
      cyc <= cyc + 1;
      if (oIMEM_RD === 1'b1) begin
         rd_addr_q.push_back(oIMEM_ADDR);
         rd_cyc_q.push_back(cyc);
      end
      if (oINSTR_VALID === 1'b1 && iINSTR_READY === 1'b1) begin
         xfer_q.push_back(oINSTR);
         xfer_cyc_q.push_back(cyc);
      end
      if (oDONE === 1'b1) begin
         done_cnt <= done_cnt + 1;
      end
      if (prev_stall && (oINSTR_VALID !== 1'b1 || oINSTR !== prev_instr)) begin
         stall_viol <= stall_viol + 1;
      end
      if (oINSTR_VALID === 1'b1 && iINSTR_READY === 1'b0 && !iABORT && !iRST) begin
         prev_stall <= 1'b1;
         stall_cnt  <= stall_cnt + 1;
      end else begin
         prev_stall <= 1'b0;
      end
      prev_instr <= oINSTR;
   end

   // Watchdog: never let the run hang.
   initial begin
      #400000;
      $display("FAIL watchdog: observed no completion, required finish before 400000ns");
      $fatal(1, "watchdog expired");
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge iACLK);
      #1;
   endtask

   task automatic launch(input logic [IABW-1:0] addr, input logic [IABW:0] cnt);
      iSTART_ADDR  = addr;
      iINSTR_COUNT = cnt;
      iSTART       = 1'b1;
      step();
      iSTART       = 1'b0;
   endtask

   task automatic run_to_idle(input logic [3:0] pat, input int maxc);
      for (int i = 0; i < maxc; i++) begin
         iINSTR_READY = pat[2'(i)];
         step();
         if (!oBUSY) break;
      end
   endtask

   int rb, xb, db, sb, vb;
   logic [IABW-1:0] wrap_a [4];

   initial begin
      iRST = 1'b1; iSTART = 1'b0; iSTART_ADDR = '0; iINSTR_COUNT = '0;
      iABORT = 1'b0; iINSTR_READY = 1'b0;
      wrap_a = '{10'h3FE, 10'h3FF, 10'h000, 10'h001};
      step(); step(); step();
      check("rst_busy",  32'(oBUSY), 32'd0);
      check("rst_done",  32'(oDONE), 32'd0);
      check("rst_rd",    32'(oIMEM_RD), 32'd0);
      check("rst_valid", 32'(oINSTR_VALID), 32'd0);
      check("rst_addr",  32'(oIMEM_ADDR), 32'd0);
      check("rst_issued", 32'(oISSUED), 32'd0);
      iRST = 1'b0;

      // 1: addr 0x010, count 5, ready high
      rb = rd_addr_q.size(); xb = xfer_q.size(); db = done_cnt;
      iINSTR_READY = 1'b1;
      launch(10'h010, 11'd5);
      check("t1_rd_lat", 32'(oIMEM_RD), 32'd1);
      check("t1_first_addr", 32'(oIMEM_ADDR), 32'h010);
      check("t1_busy", 32'(oBUSY), 32'd1);
      check("t1_valid_t1", 32'(oINSTR_VALID), 32'd0);
      step();
      check("t1_valid_t2", 32'(oINSTR_VALID), 32'd0);
      step();
      check("t1_valid_t3", 32'(oINSTR_VALID), 32'd1);
      check("t1_head_t3", oINSTR, 32'hC0DE_0010);
      run_to_idle(4'b1111, 30);
      check("t1_idle", 32'(oBUSY), 32'd0);
      check("t1_done_with_busy_drop", 32'(oDONE), 32'd1);
      check("t1_issued", 32'(oISSUED), 32'd5);
      check("t1_nreads", 32'(rd_addr_q.size() - rb), 32'd5);
      check("t1_nxfers", 32'(xfer_q.size() - xb), 32'd5);
      for (int i = 0; i < 5; i++) begin
         check("t1_rd_addr", 32'(rd_addr_q[rb + i]), 32'(16 + i));
         check("t1_xfer_data", xfer_q[xb + i], 32'hC0DE_0010 + 32'(i));
      end
      check("t1_rd_consecutive", 32'(rd_cyc_q[rb + 4] - rd_cyc_q[rb]), 32'd4);
      check("t1_xfer_consecutive", 32'(xfer_cyc_q[xb + 4] - xfer_cyc_q[xb]), 32'd4);
      step();
      check("t1_done_one_cycle", 32'(oDONE), 32'd0);
      check("t1_done_count", 32'(done_cnt - db), 32'd1);

      // 2: address wrap 0x3FE, count 4
      rb = rd_addr_q.size(); xb = xfer_q.size(); db = done_cnt;
      launch(10'h3FE, 11'd4);
      run_to_idle(4'b1111, 30);
      check("t2_idle", 32'(oBUSY), 32'd0);
      check("t2_nreads", 32'(rd_addr_q.size() - rb), 32'd4);
      check("t2_nxfers", 32'(xfer_q.size() - xb), 32'd4);
      for (int i = 0; i < 4; i++) begin
         check("t2_rd_addr", 32'(rd_addr_q[rb + i]), 32'(wrap_a[i]));
         check("t2_xfer_data", xfer_q[xb + i], mdata(wrap_a[i]));
      end
      step();
      check("t2_done_count", 32'(done_cnt - db), 32'd1);

      // 3: count 8 with ready pattern 1,0,0,1
      rb = rd_addr_q.size(); xb = xfer_q.size(); db = done_cnt;
      sb = stall_cnt; vb = stall_viol;
      launch(10'h100, 11'd8);
      run_to_idle(4'b1001, 100);
      check("t3_idle", 32'(oBUSY), 32'd0);
      check("t3_issued", 32'(oISSUED), 32'd8);
      check("t3_nreads", 32'(rd_addr_q.size() - rb), 32'd8);
      check("t3_nxfers", 32'(xfer_q.size() - xb), 32'd8);
      for (int i = 0; i < 8; i++) begin
         check("t3_xfer_data", xfer_q[xb + i], 32'hC0DE_0100 + 32'(i));
      end
      check("t3_stalls_seen", 32'(stall_cnt > sb), 32'd1);
      check("t3_stall_stable", 32'(stall_viol - vb), 32'd0);
      iINSTR_READY = 1'b1;
      step();
      check("t3_done_count", 32'(done_cnt - db), 32'd1);

      // 4: count 0
      rb = rd_addr_q.size(); db = done_cnt;
      launch(10'h055, 11'd0);
      check("t4_done", 32'(oDONE), 32'd1);
      check("t4_busy", 32'(oBUSY), 32'd0);
      check("t4_rd", 32'(oIMEM_RD), 32'd0);
      step();
      check("t4_done_one_cycle", 32'(oDONE), 32'd0);
      check("t4_busy_after", 32'(oBUSY), 32'd0);
      check("t4_no_reads", 32'(rd_addr_q.size() - rb), 32'd0);
      check("t4_done_count", 32'(done_cnt - db), 32'd1);

      // 5: abort together with start in IDLE drops the launch
      rb = rd_addr_q.size(); db = done_cnt;
      iABORT = 1'b1;
      launch(10'h066, 11'd2);
      iABORT = 1'b0;
      check("t5_busy", 32'(oBUSY), 32'd0);
      step(); step();
      check("t5_no_reads", 32'(rd_addr_q.size() - rb), 32'd0);
      check("t5_no_done", 32'(done_cnt - db), 32'd0);

      // 6: count 10, abort after 3 transfers, then a clean relaunch
      xb = xfer_q.size(); db = done_cnt;
      iINSTR_READY = 1'b1;
      launch(10'h200, 11'd10);
      for (int i = 0; i < 20; i++) begin
         step();
         if (xfer_q.size() - xb >= 3) break;
      end
      iINSTR_READY = 1'b0;
      iABORT = 1'b1;
      step();
      iABORT = 1'b0;
      check("t6_busy", 32'(oBUSY), 32'd0);
      check("t6_valid", 32'(oINSTR_VALID), 32'd0);
      check("t6_issued", 32'(oISSUED), 32'd3);
      check("t6_rd", 32'(oIMEM_RD), 32'd0);
      step(); step(); step();
      check("t6_valid_later", 32'(oINSTR_VALID), 32'd0);
      check("t6_no_done", 32'(done_cnt - db), 32'd0);
      check("t6_nxfers", 32'(xfer_q.size() - xb), 32'd3);
      for (int i = 0; i < 3; i++) begin
         check("t6_xfer_data", xfer_q[xb + i], 32'hC0DE_0200 + 32'(i));
      end
      xb = xfer_q.size(); db = done_cnt;
      launch(10'h020, 11'd3);
      run_to_idle(4'b1111, 30);
      check("t6_re_idle", 32'(oBUSY), 32'd0);
      check("t6_re_issued", 32'(oISSUED), 32'd3);
      check("t6_re_nxfers", 32'(xfer_q.size() - xb), 32'd3);
      for (int i = 0; i < 3; i++) begin
         check("t6_re_data", xfer_q[xb + i], 32'hC0DE_0020 + 32'(i));
      end
      step();
      check("t6_re_done_count", 32'(done_cnt - db), 32'd1);

      // 7: reset mid-run with two entries held, then relaunch
      iINSTR_READY = 1'b0;
      launch(10'h300, 11'd8);
      step(); step(); step();
      check("t7_pre_valid", 32'(oINSTR_VALID), 32'd1);
      iRST = 1'b1;
      step();
      check("t7_rst_busy",   32'(oBUSY), 32'd0);
      check("t7_rst_done",   32'(oDONE), 32'd0);
      check("t7_rst_rd",     32'(oIMEM_RD), 32'd0);
      check("t7_rst_valid",  32'(oINSTR_VALID), 32'd0);
      check("t7_rst_addr",   32'(oIMEM_ADDR), 32'd0);
      check("t7_rst_issued", 32'(oISSUED), 32'd0);
      iRST = 1'b0;
      rb = rd_addr_q.size(); xb = xfer_q.size(); db = done_cnt;
      iINSTR_READY = 1'b1;
      launch(10'h040, 11'd2);
      check("t7_first_start", 32'(oIMEM_RD), 32'd1);
      run_to_idle(4'b1111, 30);
      check("t7_idle", 32'(oBUSY), 32'd0);
      check("t7_issued", 32'(oISSUED), 32'd2);
      check("t7_nreads", 32'(rd_addr_q.size() - rb), 32'd2);
      check("t7_nxfers", 32'(xfer_q.size() - xb), 32'd2);
      for (int i = 0; i < 2; i++) begin
         check("t7_rd_addr", 32'(rd_addr_q[rb + i]), 32'(64 + i));
         check("t7_xfer_data", xfer_q[xb + i], 32'hC0DE_0040 + 32'(i));
      end
      step();
      check("t7_done_count", 32'(done_cnt - db), 32'd1);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
